// File: rtl/conv_acc_bank.sv
// conv_acc_bank
// Multi-lane convolution accumulator. Each beat carries LANES signed
// products that are summed and folded into a window accumulator. The
// accumulator is seeded from a run-time writable per-plane bias table on the
// first beat of a window. On the last beat of a window the result is
// saturated or truncated to DATA_W, optionally passed through ReLU, and
// presented with a one-cycle valid strobe.
//
// Ports:
//   clk, rst           - clock, synchronous active-high reset
//   in_data            - LANES x DATA_W signed lanes, lane i at [i*DATA_W +: DATA_W]
//   in_valid/first/last- beat strobe and window delimiters (qualified by in_valid)
//   plane_next         - advance the plane pointer (wraps at NUM_PLANES)
//   bias_wr_en/addr/data - bias table write port
//   out_data/out_valid - window result and one-cycle strobe
//   out_plane          - plane index whose bias seeded the result
//   out_sat            - result was clipped by saturation
//   plane_done         - one-cycle pulse when the pointer wraps to 0
module conv_acc_bank #(
    parameter int DATA_W     = 16,
    parameter int LANES      = 4,
    parameter int NUM_PLANES = 6,
    parameter int GUARD      = 8,
    parameter int SAT        = 1,
    parameter int RELU       = 0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [LANES*DATA_W-1:0]       in_data,
    input  logic                          in_valid,
    input  logic                          in_first,
    input  logic                          in_last,
    input  logic                          plane_next,
    input  logic                          bias_wr_en,
    input  logic [$clog2(NUM_PLANES)-1:0] bias_wr_addr,
    input  logic [DATA_W-1:0]             bias_wr_data,
    output logic [DATA_W-1:0]             out_data,
    output logic                          out_valid,
    output logic [$clog2(NUM_PLANES)-1:0] out_plane,
    output logic                          out_sat,
    output logic                          plane_done
);

    localparam int LANE_BITS = $clog2(LANES);
    localparam int SUM_W     = DATA_W + LANE_BITS;
    localparam int ACC_W     = SUM_W + GUARD;
    localparam int PTR_W     = $clog2(NUM_PLANES);

    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(NUM_PLANES - 1);

    // Saturation bounds expressed at accumulator width.
    localparam logic signed [ACC_W-1:0] SAT_MAX =
        {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN =
        {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    // Reduce an accumulator value to DATA_W: saturate (or wrap), then ReLU.
    // Returns {clipped_flag, data}.
    function automatic logic [DATA_W:0] post_proc(input logic [ACC_W-1:0] v);
        logic signed [ACC_W-1:0] sv;
        logic [DATA_W-1:0]       d;
        logic                    s;
        sv = v;
        if (SAT != 0) begin
            if (sv > SAT_MAX) begin
                d = SAT_MAX[DATA_W-1:0];
                s = 1'b1;
            end else if (sv < SAT_MIN) begin
                d = SAT_MIN[DATA_W-1:0];
                s = 1'b1;
            end else begin
                d = v[DATA_W-1:0];
                s = 1'b0;
            end
        end else begin
            d = v[DATA_W-1:0];
            s = 1'b0;
        end
        if ((RELU != 0) && d[DATA_W-1]) begin
            d = '0;
        end else begin
            d = d;
        end
        return {s, d};
    endfunction

    logic [SUM_W-1:0]  lane_sum_s;
    logic [ACC_W-1:0]  bias_ext_s;
    logic [ACC_W-1:0]  sum_ext_s;
    logic [ACC_W-1:0]  acc_next_s;
    logic [DATA_W:0]   post_s;

    logic [SUM_W-1:0]  s1_sum_r;
    logic              s1_valid_r;
    logic              s1_first_r;
    logic              s1_last_r;
    logic [PTR_W-1:0]  s1_ptr_r;
    logic [PTR_W-1:0]  ptr_r;
    logic [ACC_W-1:0]  acc_r;
    logic [DATA_W-1:0] bias_r [NUM_PLANES];

    // Exact sign-extended sum of all lanes of the incoming beat.
    always_comb begin
        lane_sum_s = '0;
        for (int i = 0; i < LANES; i++) begin
            lane_sum_s = lane_sum_s +
                {{LANE_BITS{in_data[i*DATA_W+DATA_W-1]}}, in_data[i*DATA_W +: DATA_W]};
        end
    end

    // Next accumulator value: bias-seeded on first beat, running sum otherwise.
    always_comb begin
        bias_ext_s = {{(ACC_W-DATA_W){bias_r[s1_ptr_r][DATA_W-1]}}, bias_r[s1_ptr_r]};
        sum_ext_s  = {{GUARD{s1_sum_r[SUM_W-1]}}, s1_sum_r};
        if (s1_first_r) begin
            acc_next_s = bias_ext_s + sum_ext_s;
        end else begin
            acc_next_s = acc_r + sum_ext_s;
        end
        post_s = post_proc(acc_next_s);
    end

    // Stage 1: capture beat sum, qualified flags and the pointer in use.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_sum_r   <= '0;
            s1_valid_r <= 1'b0;
            s1_first_r <= 1'b0;
            s1_last_r  <= 1'b0;
            s1_ptr_r   <= '0;
        end else begin
            s1_sum_r   <= lane_sum_s;
            s1_valid_r <= in_valid;
            s1_first_r <= in_valid & in_first;
            s1_last_r  <= in_valid & in_last;
            s1_ptr_r   <= ptr_r;
        end
    end

    // Plane pointer with wrap pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_r      <= '0;
            plane_done <= 1'b0;
        end else if (plane_next) begin
            if (ptr_r == LAST_PTR) begin
                ptr_r      <= '0;
                plane_done <= 1'b1;
            end else begin
                ptr_r      <= ptr_r + PTR_W'(1);
                plane_done <= 1'b0;
            end
        end else begin
            plane_done <= 1'b0;
        end
    end

    // Bias table; out-of-range addresses match no entry and are dropped.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_PLANES; i++) begin
            if (rst) begin
                bias_r[i] <= '0;
            end else if (bias_wr_en && (bias_wr_addr == PTR_W'(i))) begin
                bias_r[i] <= bias_wr_data;
            end else begin
                bias_r[i] <= bias_r[i];
            end
        end
    end

    // Stage 2: accumulate and register the window result on the last beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_r     <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            out_plane <= '0;
            out_sat   <= 1'b0;
        end else if (s1_valid_r) begin
            acc_r <= acc_next_s;
            if (s1_last_r) begin
                out_data  <= post_s[DATA_W-1:0];
                out_sat   <= post_s[DATA_W];
                out_plane <= s1_ptr_r;
                out_valid <= 1'b1;
            end else begin
                out_valid <= 1'b0;
            end
        end else begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_conv_acc_bank.sv
module tb_conv_acc_bank;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] in_data;
    logic        in_valid, in_first, in_last, plane_next;
    logic        bias_wr_en;
    logic [2:0]  bias_wr_addr;
    logic [15:0] bias_wr_data;

    logic [15:0] od_a, od_w, od_r;
    logic        ov_a, ov_w, ov_r;
    logic [2:0]  op_a, op_w, op_r;
    logic        os_a, os_w, os_r;
    logic        pd_a, pd_w, pd_r;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    conv_acc_bank #(.SAT(1), .RELU(0)) u_dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_first(in_first), .in_last(in_last), .plane_next(plane_next),
        .bias_wr_en(bias_wr_en), .bias_wr_addr(bias_wr_addr), .bias_wr_data(bias_wr_data),
        .out_data(od_a), .out_valid(ov_a), .out_plane(op_a), .out_sat(os_a), .plane_done(pd_a));

    conv_acc_bank #(.SAT(0), .RELU(0)) u_wrap (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_first(in_first), .in_last(in_last), .plane_next(plane_next),
        .bias_wr_en(bias_wr_en), .bias_wr_addr(bias_wr_addr), .bias_wr_data(bias_wr_data),
        .out_data(od_w), .out_valid(ov_w), .out_plane(op_w), .out_sat(os_w), .plane_done(pd_w));

    conv_acc_bank #(.SAT(1), .RELU(1)) u_relu (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_first(in_first), .in_last(in_last), .plane_next(plane_next),
        .bias_wr_en(bias_wr_en), .bias_wr_addr(bias_wr_addr), .bias_wr_data(bias_wr_data),
        .out_data(od_r), .out_valid(ov_r), .out_plane(op_r), .out_sat(os_r), .plane_done(pd_r));

    typedef struct {
        logic [63:0] data;
        logic        pn;
        logic [15:0] exp_data;
        logic [2:0]  exp_plane;
        logic        exp_done;
    } vec_t;

    vec_t tbl [0:8];

    function automatic logic [63:0] pack4(input int a, input int b, input int c, input int d);
        return {d[15:0], c[15:0], b[15:0], a[15:0]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_beat(input logic [63:0] d, input logic f, input logic l, input logic pn);
        in_data    = d;
        in_valid   = 1'b1;
        in_first   = f;
        in_last    = l;
        plane_next = pn;
    endtask

    task automatic idle();
        in_data    = 64'd0;
        in_valid   = 1'b0;
        in_first   = 1'b0;
        in_last    = 1'b0;
        plane_next = 1'b0;
    endtask

    initial begin
        logic [15:0] biases [0:5];
        biases = '{16'd3, 16'hFFFB, 16'd42, 16'd18, 16'd20, 16'd29};

        // Back-to-back single-beat windows after biases are loaded, ptr at 0.
        tbl[0] = '{pack4(1, 2, 3, 4),     1'b0, 16'd13,   3'd0, 1'b0};
        tbl[1] = '{pack4(-1, -1, -1, -1), 1'b1, 16'hFFFF, 3'd0, 1'b0};
        tbl[2] = '{pack4(0, 0, 0, 0),     1'b0, 16'hFFFB, 3'd1, 1'b0};
        tbl[3] = '{pack4(100, 200, -50, 7), 1'b1, 16'd252, 3'd1, 1'b0};
        tbl[4] = '{pack4(0, 0, 0, 1),     1'b1, 16'd43,   3'd2, 1'b0};
        tbl[5] = '{pack4(10, 10, 10, 10), 1'b1, 16'd58,   3'd3, 1'b0};
        tbl[6] = '{pack4(-20, 0, 0, 0),   1'b1, 16'd0,    3'd4, 1'b0};
        tbl[7] = '{pack4(1, 1, 1, 1),     1'b1, 16'd33,   3'd5, 1'b1};
        tbl[8] = '{pack4(2, 0, 0, 0),     1'b0, 16'd5,    3'd0, 1'b0};

        rst = 1'b1;
        idle();
        bias_wr_en = 1'b0; bias_wr_addr = 3'd0; bias_wr_data = 16'd0;
        tick(); tick();
        rst = 1'b0;
        chk("rst_valid", {31'd0, ov_a}, 32'd0);
        chk("rst_data",  {16'd0, od_a}, 32'd0);
        chk("rst_plane", {29'd0, op_a}, 32'd0);
        chk("rst_sat",   {31'd0, os_a}, 32'd0);
        chk("rst_done",  {31'd0, pd_a}, 32'd0);

        // Load bias table, plus an out-of-range write that must be dropped.
        for (int i = 0; i < 6; i++) begin
            bias_wr_en = 1'b1; bias_wr_addr = 3'(i); bias_wr_data = biases[i];
            tick();
        end
        bias_wr_addr = 3'd7; bias_wr_data = 16'h1234;
        tick();
        bias_wr_en = 1'b0;

        // Multi-beat window: 3 + 3*10 = 33.
        set_beat(pack4(1, 2, 3, 4), 1'b1, 1'b0, 1'b0); tick();
        set_beat(pack4(1, 2, 3, 4), 1'b0, 1'b0, 1'b0); tick();
        chk("mb_mid_valid", {31'd0, ov_a}, 32'd0);
        set_beat(pack4(1, 2, 3, 4), 1'b0, 1'b1, 1'b0); tick();
        idle();
        chk("mb_early_valid", {31'd0, ov_a}, 32'd0);
        tick();
        chk("mb_valid", {31'd0, ov_a}, 32'd1);
        chk("mb_data",  {16'd0, od_a}, 32'd33);
        chk("mb_plane", {29'd0, op_a}, 32'd0);
        chk("mb_sat",   {31'd0, os_a}, 32'd0);
        tick();
        chk("mb_pulse_end", {31'd0, ov_a}, 32'd0);

        // Table: back-to-back windows, plane advance, wrap pulse.
        for (int k = 0; k <= 9; k++) begin
            if (k < 9) set_beat(tbl[k].data, 1'b1, 1'b1, tbl[k].pn);
            else       idle();
            tick();
            if (k < 9) chk($sformatf("tbl%0d_done", k), {31'd0, pd_a}, {31'd0, tbl[k].exp_done});
            chk($sformatf("tbl%0d_valid", k), {31'd0, ov_a}, (k >= 1) ? 32'd1 : 32'd0);
            if (k >= 1) begin
                chk($sformatf("tbl%0d_data", k - 1),  {16'd0, od_a}, {16'd0, tbl[k-1].exp_data});
                chk($sformatf("tbl%0d_plane", k - 1), {29'd0, op_a}, {29'd0, tbl[k-1].exp_plane});
                chk($sformatf("tbl%0d_sat", k - 1),   {31'd0, os_a}, 32'd0);
            end
        end
        tick();
        chk("tbl_idle_valid", {31'd0, ov_a}, 32'd0);

        // Simultaneous: beat with plane_next, then bias write to the read entry.
        set_beat(pack4(1, 0, 0, 0), 1'b1, 1'b1, 1'b1); tick();
        idle();
        bias_wr_en = 1'b1; bias_wr_addr = 3'd0; bias_wr_data = 16'd100;
        tick();
        bias_wr_en = 1'b0;
        chk("sim_valid", {31'd0, ov_a}, 32'd1);
        chk("sim_data",  {16'd0, od_a}, 32'd4);
        chk("sim_plane", {29'd0, op_a}, 32'd0);
        for (int i = 0; i < 5; i++) begin
            plane_next = 1'b1;
            tick();
            chk($sformatf("wrap_done%0d", i), {31'd0, pd_a}, (i == 4) ? 32'd1 : 32'd0);
        end
        plane_next = 1'b0;
        tick();
        chk("wrap_done_end", {31'd0, pd_a}, 32'd0);
        set_beat(pack4(0, 0, 0, 0), 1'b1, 1'b1, 1'b0); tick();
        idle(); tick();
        chk("newbias_valid", {31'd0, ov_a}, 32'd1);
        chk("newbias_data",  {16'd0, od_a}, 32'd100);
        chk("newbias_plane", {29'd0, op_a}, 32'd0);

        // Reset mid-window: window is discarded and biases cleared.
        set_beat(pack4(1, 1, 1, 1), 1'b1, 1'b0, 1'b0); tick();
        set_beat(pack4(1, 1, 1, 1), 1'b0, 1'b0, 1'b0); tick();
        idle();
        rst = 1'b1; tick(); rst = 1'b0;
        chk("mrst_data",  {16'd0, od_a}, 32'd0);
        chk("mrst_valid", {31'd0, ov_a}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("mrst_quiet%0d", i), {31'd0, ov_a}, 32'd0);
        end
        set_beat(pack4(1, 1, 1, 1), 1'b1, 1'b1, 1'b0); tick();
        idle(); tick();
        chk("mrst_new_valid", {31'd0, ov_a}, 32'd1);
        chk("mrst_new_data",  {16'd0, od_a}, 32'd4);
        chk("mrst_new_plane", {29'd0, op_a}, 32'd0);

        // Saturation vs wrap vs ReLU, bias 0 on plane 0.
        for (int b = 0; b < 4; b++) begin
            set_beat({4{16'h7FFF}}, (b == 0), (b == 3), 1'b0); tick();
        end
        idle(); tick();
        chk("satp_valid",    {31'd0, ov_a}, 32'd1);
        chk("satp_data",     {16'd0, od_a}, 32'h7FFF);
        chk("satp_sat",      {31'd0, os_a}, 32'd1);
        chk("wrapp_data",    {16'd0, od_w}, 32'hFFF0);
        chk("wrapp_sat",     {31'd0, os_w}, 32'd0);
        chk("relup_data",    {16'd0, od_r}, 32'h7FFF);
        for (int b = 0; b < 4; b++) begin
            set_beat({4{16'h8000}}, (b == 0), (b == 3), 1'b0); tick();
        end
        idle(); tick();
        chk("satn_valid",    {31'd0, ov_a}, 32'd1);
        chk("satn_data",     {16'd0, od_a}, 32'h8000);
        chk("satn_sat",      {31'd0, os_a}, 32'd1);
        chk("wrapn_data",    {16'd0, od_w}, 32'h0000);
        chk("wrapn_sat",     {31'd0, os_w}, 32'd0);
        chk("relun_data",    {16'd0, od_r}, 32'h0000);
        chk("relun_valid",   {31'd0, ov_r}, 32'd1);
        tick();
        chk("satn_pulse_end", {31'd0, ov_a}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
